// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: one 128-bit state is substituted LANES bytes per
// cycle through shared S-box instances, then held until downstream takes it.

// One FIPS-197 S-box, computed as affine(x^254) over GF(2^8) mod 0x11B.
module sub_bytes_sbox (
    input  logic [7:0] i_x,
    output logic [7:0] o_y
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_inv;

    // x^254 is the multiplicative inverse and naturally maps 0 to 0
    always_comb begin
        logic [7:0] p;
        p     = i_x;
        w_inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p     = gmul(p, p);
            w_inv = gmul(w_inv, p);
        end
    end

    assign o_y = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;
endmodule

module sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int NCH = 16 / LANES;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [CW-1:0]           r_cnt;
    logic [127:0]            r_data;
    logic [LANES-1:0][7:0]   w_src;
    logic [LANES-1:0][7:0]   w_sub;

    // Pick the chunk of bytes addressed by the counter
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            w_src[j] = r_data[(int'(r_cnt) * LANES + j) * 8 +: 8];
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            sub_bytes_sbox u_sbox (.i_x(w_src[g]), .o_y(w_sub[g]));
        end
    endgenerate

    // Next-state logic; DONE never accepts, even on the output handshake cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)      w_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
            S_DONE:  if (out_ready)     w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    // State, chunk counter and in-place substituted data register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data <= in_data;
                        r_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    for (int j = 0; j < LANES; j++) begin
                        r_data[(int'(r_cnt) * LANES + j) * 8 +: 8] <= w_sub[j];
                    end
                    r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign out_data  = r_data;
endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter: FIPS vector, byte corners, backpressure,
// back-to-back streaming, mid-run reset and a LANES sweep.
module tb_sub_bytes_iter;
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         busy;

    // Sweep instances for the other LANES values
    localparam int SW_L   [4] = '{1, 2, 8, 16};
    localparam int SW_LAT [4] = '{16, 8, 2, 1};
    logic         sw_in_valid = 1'b0;
    logic [127:0] sw_in_data  = '0;
    logic         sw_out_ready = 1'b1;
    wire  [3:0]          sw_ir;
    wire  [3:0]          sw_ov;
    wire  [3:0]          sw_busy;
    wire  [3:0][127:0]   sw_od;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sub_bytes_iter #(.LANES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sw
            sub_bytes_iter #(.LANES(SW_L[g])) u_sw (
                .clk(clk), .rst(rst),
                .in_valid(sw_in_valid), .in_ready(sw_ir[g]), .in_data(sw_in_data),
                .out_valid(sw_ov[g]), .out_ready(sw_out_ready), .out_data(sw_od[g]),
                .busy(sw_busy[g])
            );
        end
    endgenerate

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Called #1 after an edge. Offers din, waits for accept, then measures
    // edges from the accept edge to out_valid. out_ready is left as-is.
    task automatic xfer(input logic [127:0] din, output logic [127:0] dout,
                        output int lat, output bit ok);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = din;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        ok   = out_valid;
        dout = out_data;
    endtask

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
        string        nm;
    } vec_t;

    vec_t tv [5];

    initial begin
        logic [127:0] d;
        int           lat;
        bit           ok;
        logic [127:0] bb_in  [3];
        logic [127:0] bb_exp [3];
        logic [127:0] got    [4];
        int           tcyc   [4];
        int           nout;
        int           acc;
        int           sw_lat [4];
        logic [127:0] sw_dat [4];

        tv[0] = '{FIPS_IN,          FIPS_OUT,         "fips"};
        tv[1] = '{{16{8'h00}},      {16{8'h63}},      "zero"};
        tv[2] = '{{16{8'hff}},      {16{8'h16}},      "ones"};
        tv[3] = '{{16{8'h53}},      {16{8'hed}},      "x53"};
        tv[4] = '{{16{8'h01}},      {16{8'h7c}},      "x01"};

        // Reset state while rst is held high
        #12;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_in_ready",  128'(in_ready),  128'd0);
        chk("rst_busy",      128'(busy),      128'd0);
        chk("rst_out_data",  out_data,        128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", 128'(in_ready), 128'd1);

        // Table vectors, out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            xfer(tv[i].din, d, lat, ok);
            chk({tv[i].nm, "_valid"},   128'(ok),  128'd1);
            chk({tv[i].nm, "_data"},    d,         tv[i].dout);
            chk({tv[i].nm, "_latency"}, 128'(lat), 128'd4);
            @(posedge clk); #1;
            chk({tv[i].nm, "_back_idle"}, 128'(in_ready), 128'd1);
        end

        // Backpressure: 10 stalled cycles in DONE
        out_ready = 1'b0;
        xfer({16{8'h53}}, d, lat, ok);
        chk("bp_valid", 128'(ok), 128'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 128'(out_valid), 128'd1);
            chk("bp_hold_data",  out_data,        {16{8'hed}});
            chk("bp_in_ready",   128'(in_ready),  128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 128'(out_valid), 128'd0);
        chk("bp_release_ready", 128'(in_ready),  128'd1);
        chk("bp_release_busy",  128'(busy),      128'd0);

        // Back-to-back with in_valid held high
        bb_in[0] = FIPS_IN;      bb_exp[0] = FIPS_OUT;
        bb_in[1] = {16{8'hff}};  bb_exp[1] = {16{8'h16}};
        bb_in[2] = {16{8'h01}};  bb_exp[2] = {16{8'h7c}};
        nout = 0;
        acc  = 0;
        in_valid = 1'b1;
        in_data  = bb_in[0];
        for (int cyc = 0; cyc < 40; cyc++) begin
            bit take;
            take = in_ready && in_valid;
            if (out_valid && out_ready) begin
                if (nout < 4) begin
                    got[nout]  = out_data;
                    tcyc[nout] = cyc;
                end
                nout++;
            end
            @(posedge clk); #1;
            if (take) begin
                acc++;
                if (acc < 3) in_data = bb_in[acc];
                else         in_valid = 1'b0;
            end
        end
        chk("b2b_count", 128'(nout), 128'd3);
        if (nout >= 3) begin
            for (int i = 0; i < 3; i++) chk("b2b_data", got[i], bb_exp[i]);
            chk("b2b_gap01", 128'(tcyc[1] - tcyc[0]), 128'd6);
            chk("b2b_gap12", 128'(tcyc[2] - tcyc[1]), 128'd6);
        end

        // Reset two cycles into RUN
        in_valid = 1'b1;
        in_data  = {16{8'hff}};
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mr_busy_before", 128'(busy), 128'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mr_out_valid", 128'(out_valid), 128'd0);
        chk("mr_in_ready",  128'(in_ready),  128'd0);
        chk("mr_busy",      128'(busy),      128'd0);
        chk("mr_out_data",  out_data,        128'd0);
        @(posedge clk); #1;
        chk("mr_hold_ready", 128'(in_ready), 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(FIPS_IN, d, lat, ok);
        chk("mr_after_valid", 128'(ok),  128'd1);
        chk("mr_after_data",  d,         FIPS_OUT);
        chk("mr_after_lat",   128'(lat), 128'd4);
        @(posedge clk); #1;

        // LANES sweep
        chk("sw_ready", 128'(sw_ir), 128'hf);
        for (int k = 0; k < 4; k++) begin
            sw_lat[k] = 0;
            sw_dat[k] = '0;
        end
        sw_in_valid = 1'b1;
        sw_in_data  = FIPS_IN;
        @(posedge clk); #1;
        sw_in_valid = 1'b0;
        sw_in_data  = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                if (sw_ov[k] && sw_lat[k] == 0) begin
                    sw_lat[k] = n;
                    sw_dat[k] = sw_od[k];
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sweep_L%0d_data", SW_L[k]), sw_dat[k], FIPS_OUT);
            chk($sformatf("sweep_L%0d_lat", SW_L[k]), 128'(sw_lat[k]), 128'(SW_LAT[k]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
